rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 134 +++++++++++++
 tb/tb_rom_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one synchronous ROM between a fetch port (0) and a data
// port (1). One read is granted per cycle; each result comes back on its own
// port two cycles after the grant.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   REQ0/1, ADDR0/1   read requests (ADDR held stable while REQ is high)
//   GNT0/1            combinational grant, request accepted this cycle
//   VALID0/1          registered one-cycle pulse, DATAx holds a new result
//   DATA0/1           registered last read result per port
//   ROM_ADDRESS       combinational address to the synchronous ROM
//   ROM_DATA          ROM output, one cycle after its address
module rom_arbiter #(
  parameter int unsigned BITS           = 16,
  parameter int unsigned ADDRESS_BITS   = 8,
  parameter int unsigned FIXED_PRIORITY = 0,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ0,
  input  logic                    REQ1,
  input  logic [ADDRESS_BITS-1:0] ADDR0,
  input  logic [ADDRESS_BITS-1:0] ADDR1,
  output logic                    GNT0,
  output logic                    GNT1,
  output logic                    VALID0,
  output logic                    VALID1,
  output logic [BITS-1:0]         DATA0,
  output logic [BITS-1:0]         DATA1,
  output logic [ADDRESS_BITS-1:0] ROM_ADDRESS,
  input  logic [BITS-1:0]         ROM_DATA
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic                    gnt0_c, gnt1_c;
  logic                    last_q, last_d;
  logic [ADDRESS_BITS-1:0] last_addr_q, last_addr_d;
  logic [CNT_W-1:0]        starve_cnt_q, starve_cnt_d;
  logic                    s1_vld_q, s1_vld_d;
  logic                    s1_port_q, s1_port_d;
  logic                    valid0_q, valid0_d;
  logic                    valid1_q, valid1_d;
  logic [BITS-1:0]         data0_q, data0_d;
  logic [BITS-1:0]         data1_q, data1_d;

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!RST) begin
      if (REQ0 && REQ1) begin
        if (FIXED_PRIORITY != 0) begin
          // Port 0 wins ties until port 1 has waited STARVE_LIMIT cycles.
          if (starve_cnt_q == LIMIT) gnt1_c = 1'b1;
          else                       gnt0_c = 1'b1;
        end else begin
          // Round-robin: the port that did not win last time goes now.
          if (last_q) gnt0_c = 1'b1;
          else        gnt1_c = 1'b1;
        end
      end else if (REQ0) begin
        gnt0_c = 1'b1;
      end else if (REQ1) begin
        gnt1_c = 1'b1;
      end
    end
  end

  // Next-state for arbitration history and the two-stage read pipeline.
  always_comb begin
    last_d       = last_q;
    last_addr_d  = last_addr_q;
    starve_cnt_d = '0;
    s1_vld_d     = gnt0_c | gnt1_c;
    s1_port_d    = gnt1_c;
    valid0_d     = s1_vld_q & ~s1_port_q;
    valid1_d     = s1_vld_q & s1_port_q;
    data0_d      = data0_q;
    data1_d      = data1_q;

    if (gnt0_c) begin
      last_d      = 1'b0;
      last_addr_d = ADDR0;
    end else if (gnt1_c) begin
      last_d      = 1'b1;
      last_addr_d = ADDR1;
    end

    if (REQ1 && !gnt1_c) begin
      starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + CNT_W'(1);
    end

    // ROM_DATA now answers the address granted last cycle.
    if (s1_vld_q && !s1_port_q) data0_d = ROM_DATA;
    if (s1_vld_q && s1_port_q)  data1_d = ROM_DATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q       <= 1'b1;
      last_addr_q  <= '0;
      starve_cnt_q <= '0;
      s1_vld_q     <= 1'b0;
      s1_port_q    <= 1'b0;
      valid0_q     <= 1'b0;
      valid1_q     <= 1'b0;
      data0_q      <= '0;
      data1_q      <= '0;
    end else begin
      last_q       <= last_d;
      last_addr_q  <= last_addr_d;
      starve_cnt_q <= starve_cnt_d;
      s1_vld_q     <= s1_vld_d;
      s1_port_q    <= s1_port_d;
      valid0_q     <= valid0_d;
      valid1_q     <= valid1_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
    end
  end

  assign GNT0        = gnt0_c;
  assign GNT1        = gnt1_c;
  // Granted address passes straight through; otherwise hold the last one.
  assign ROM_ADDRESS = last_addr_d;
  assign VALID0      = valid0_q;
  assign VALID1      = valid1_q;
  assign DATA0       = data0_q;
  assign DATA1       = data1_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a round-robin instance and a fixed-priority instance
// share the same requests, each with its own synchronous ROM (addr ^ 16'hA500).
module tb_rom_arbiter;

  localparam int unsigned BITS  = 16;
  localparam int unsigned AW    = 8;
  localparam int          LIMIT = 4;
  localparam int          HIST  = 4096;
  localparam int          NTBL  = 26;

  typedef struct packed {
    logic            rst, r0, r1;
    logic [AW-1:0]   a0, a1;
    logic            g0, g1, v0, v1;
    logic [BITS-1:0] d0, d1;
    logic [AW-1:0]   ra;
  } vec_t;

  logic clk = 1'b0;
  logic rst, req0, req1;
  logic [AW-1:0] addr0, addr1;

  logic gnt0_rr, gnt1_rr, valid0_rr, valid1_rr;
  logic gnt0_fp, gnt1_fp, valid0_fp, valid1_fp;
  logic [BITS-1:0] data0_rr, data1_rr, data0_fp, data1_fp;
  logic [BITS-1:0] rom_data_rr, rom_data_fp;
  logic [AW-1:0]   rom_addr_rr, rom_addr_fp;

  always #5 clk = ~clk;

  rom_arbiter #(.BITS(BITS), .ADDRESS_BITS(AW), .FIXED_PRIORITY(0), .STARVE_LIMIT(LIMIT)) u_rr (
    .CLK(clk), .RST(rst), .REQ0(req0), .REQ1(req1), .ADDR0(addr0), .ADDR1(addr1),
    .GNT0(gnt0_rr), .GNT1(gnt1_rr), .VALID0(valid0_rr), .VALID1(valid1_rr),
    .DATA0(data0_rr), .DATA1(data1_rr), .ROM_ADDRESS(rom_addr_rr), .ROM_DATA(rom_data_rr)
  );

  rom_arbiter #(.BITS(BITS), .ADDRESS_BITS(AW), .FIXED_PRIORITY(1), .STARVE_LIMIT(LIMIT)) u_fp (
    .CLK(clk), .RST(rst), .REQ0(req0), .REQ1(req1), .ADDR0(addr0), .ADDR1(addr1),
    .GNT0(gnt0_fp), .GNT1(gnt1_fp), .VALID0(valid0_fp), .VALID1(valid1_fp),
    .DATA0(data0_fp), .DATA1(data1_fp), .ROM_ADDRESS(rom_addr_fp), .ROM_DATA(rom_data_fp)
  );

  // Synchronous ROM models
  always_ff @(posedge clk) begin
    rom_data_rr <= BITS'(rom_addr_rr) ^ 16'hA500;
    rom_data_fp <= BITS'(rom_addr_fp) ^ 16'hA500;
  end

  int n_vec, n_bad, cyc, floor_c;
  int m_last [2];
  int m_starve [2];
  logic [AW-1:0]   m_laddr [2];
  logic [BITS-1:0] m_data [2][2];
  int              gp [2][HIST];
  logic [AW-1:0]   ga [2][HIST];
  vec_t tbl [NTBL];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference: expected grant from the arbitration rules; each grant is
  // remembered per cycle and its result is due two cycles later.
  task automatic model_cycle();
    int g;
    logic ev;
    logic [AW-1:0] er;
    logic act_v, act_g0, act_g1;
    logic [BITS-1:0] act_d;
    logic [AW-1:0] act_ra;
    string nm;
    for (int d = 0; d < 2; d++) begin
      nm = (d == 0) ? "rr" : "fp";
      if (rst)                 g = -1;
      else if (req0 && req1)   g = (d == 0) ? ((m_last[d] == 1) ? 0 : 1)
                                            : ((m_starve[d] == LIMIT) ? 1 : 0);
      else if (req0)           g = 0;
      else if (req1)           g = 1;
      else                     g = -1;
      if (rst) begin
        m_data[d][0] = '0;
        m_data[d][1] = '0;
        m_laddr[d]   = '0;
      end
      for (int p = 0; p < 2; p++) begin
        ev = !rst && cyc >= 2 && (cyc - 2) >= floor_c && gp[d][cyc-2] == p;
        if (ev) m_data[d][p] = BITS'(ga[d][cyc-2]) ^ 16'hA500;
        if (d == 0) begin
          act_v = (p == 0) ? valid0_rr : valid1_rr;
          act_d = (p == 0) ? data0_rr : data1_rr;
        end else begin
          act_v = (p == 0) ? valid0_fp : valid1_fp;
          act_d = (p == 0) ? data0_fp : data1_fp;
        end
        chk($sformatf("%s.valid%0d", nm, p), 32'(act_v), 32'(ev));
        chk($sformatf("%s.data%0d", nm, p), 32'(act_d), 32'(m_data[d][p]));
      end
      act_g0 = (d == 0) ? gnt0_rr : gnt0_fp;
      act_g1 = (d == 0) ? gnt1_rr : gnt1_fp;
      act_ra = (d == 0) ? rom_addr_rr : rom_addr_fp;
      er = (g == 0) ? addr0 : (g == 1) ? addr1 : m_laddr[d];
      chk($sformatf("%s.gnt0", nm), 32'(act_g0), 32'(g == 0));
      chk($sformatf("%s.gnt1", nm), 32'(act_g1), 32'(g == 1));
      chk($sformatf("%s.rom_addr", nm), 32'(act_ra), 32'(er));
      gp[d][cyc] = g;
      ga[d][cyc] = er;
      if (g >= 0) begin
        m_last[d]  = g;
        m_laddr[d] = er;
      end
      if (rst) begin
        m_last[d]   = 1;
        m_starve[d] = 0;
      end else if (req1 && g != 1) begin
        m_starve[d] = (m_starve[d] + 1 > LIMIT) ? LIMIT : m_starve[d] + 1;
      end else begin
        m_starve[d] = 0;
      end
    end
    if (rst) floor_c = cyc + 1;
    cyc++;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic q0, input logic q1,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic g0, input logic g1, input logic v0, input logic v1,
                              input logic [BITS-1:0] d0, input logic [BITS-1:0] d1,
                              input logic [AW-1:0] ra);
    vec_t v;
    v.rst = r; v.r0 = q0; v.r1 = q1; v.a0 = a0; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1; v.ra = ra;
    return v;
  endfunction

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0; floor_c = 0;
    for (int d = 0; d < 2; d++) begin
      m_last[d] = 1; m_starve[d] = 0; m_laddr[d] = '0;
      m_data[d][0] = '0; m_data[d][1] = '0;
    end

    // Directed rows for the round-robin instance, one row per cycle.
    tbl[0]  = mk(0,1,0,8'h05,8'h00, 1,0, 0,0, 16'h0000,16'h0000, 8'h05);
    tbl[1]  = mk(0,0,0,8'h00,8'h00, 0,0, 0,0, 16'h0000,16'h0000, 8'h05);
    tbl[2]  = mk(0,0,0,8'h00,8'h00, 0,0, 1,0, 16'hA505,16'h0000, 8'h05);
    tbl[3]  = mk(1,1,0,8'h05,8'h00, 0,0, 0,0, 16'h0000,16'h0000, 8'h00);
    tbl[4]  = mk(0,1,1,8'h10,8'h20, 1,0, 0,0, 16'h0000,16'h0000, 8'h10);
    tbl[5]  = mk(0,1,1,8'h10,8'h20, 0,1, 0,0, 16'h0000,16'h0000, 8'h20);
    tbl[6]  = mk(0,1,1,8'h10,8'h20, 1,0, 1,0, 16'hA510,16'h0000, 8'h10);
    tbl[7]  = mk(0,1,1,8'h10,8'h20, 0,1, 0,1, 16'hA510,16'hA520, 8'h20);
    tbl[8]  = mk(0,0,0,8'h00,8'h00, 0,0, 1,0, 16'hA510,16'hA520, 8'h20);
    tbl[9]  = mk(0,0,0,8'h00,8'h00, 0,0, 0,1, 16'hA510,16'hA520, 8'h20);
    tbl[10] = mk(0,0,0,8'h00,8'h00, 0,0, 0,0, 16'hA510,16'hA520, 8'h20);
    tbl[11] = mk(0,0,1,8'h00,8'h30, 0,1, 0,0, 16'hA510,16'hA520, 8'h30);
    tbl[12] = mk(0,1,0,8'h40,8'h00, 1,0, 0,0, 16'hA510,16'hA520, 8'h40);
    tbl[13] = mk(0,1,0,8'h41,8'h00, 1,0, 0,1, 16'hA510,16'hA530, 8'h41);
    tbl[14] = mk(0,1,0,8'h42,8'h00, 1,0, 1,0, 16'hA540,16'hA530, 8'h42);
    tbl[15] = mk(0,1,0,8'h43,8'h00, 1,0, 1,0, 16'hA541,16'hA530, 8'h43);
    tbl[16] = mk(0,0,0,8'h00,8'h00, 0,0, 1,0, 16'hA542,16'hA530, 8'h43);
    tbl[17] = mk(0,0,0,8'h00,8'h00, 0,0, 1,0, 16'hA543,16'hA530, 8'h43);
    tbl[18] = mk(0,0,0,8'h00,8'h00, 0,0, 0,0, 16'hA543,16'hA530, 8'h43);
    tbl[19] = mk(0,1,0,8'h07,8'h00, 1,0, 0,0, 16'hA543,16'hA530, 8'h07);
    tbl[20] = mk(1,0,0,8'h00,8'h00, 0,0, 0,0, 16'h0000,16'h0000, 8'h00);
    tbl[21] = mk(0,0,0,8'h00,8'h00, 0,0, 0,0, 16'h0000,16'h0000, 8'h00);
    tbl[22] = mk(0,0,0,8'h00,8'h00, 0,0, 0,0, 16'h0000,16'h0000, 8'h00);
    tbl[23] = mk(0,1,1,8'h11,8'h22, 1,0, 0,0, 16'h0000,16'h0000, 8'h11);
    tbl[24] = mk(0,0,0,8'h00,8'h00, 0,0, 0,0, 16'h0000,16'h0000, 8'h11);
    tbl[25] = mk(0,0,0,8'h00,8'h00, 0,0, 1,0, 16'hA511,16'h0000, 8'h11);

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    repeat (2) begin
      @(negedge clk);
      model_cycle();
      next_edge();
    end

    for (int i = 0; i < NTBL; i++) begin
      rst = tbl[i].rst; req0 = tbl[i].r0; req1 = tbl[i].r1;
      addr0 = tbl[i].a0; addr1 = tbl[i].a1;
      @(negedge clk);
      model_cycle();
      chk($sformatf("tbl%0d.gnt0", i), 32'(gnt0_rr), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d.gnt1", i), 32'(gnt1_rr), 32'(tbl[i].g1));
      chk($sformatf("tbl%0d.valid0", i), 32'(valid0_rr), 32'(tbl[i].v0));
      chk($sformatf("tbl%0d.valid1", i), 32'(valid1_rr), 32'(tbl[i].v1));
      chk($sformatf("tbl%0d.data0", i), 32'(data0_rr), 32'(tbl[i].d0));
      chk($sformatf("tbl%0d.data1", i), 32'(data1_rr), 32'(tbl[i].d1));
      chk($sformatf("tbl%0d.rom_addr", i), 32'(rom_addr_rr), 32'(tbl[i].ra));
      next_edge();
    end

    // Fixed priority with starvation guard: both ports held for 10 cycles.
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    model_cycle();
    next_edge();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 8'h50; addr1 = 8'h60;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      model_cycle();
      chk($sformatf("starve%0d.gnt0", i), 32'(gnt0_fp), 32'(!(i == 4 || i == 9)));
      chk($sformatf("starve%0d.gnt1", i), 32'(gnt1_fp), 32'(i == 4 || i == 9));
      next_edge();
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rst   = ($urandom_range(0, 63) == 0);
      req0  = ($urandom_range(0, 3) != 0);
      req1  = ($urandom_range(0, 3) != 0);
      addr0 = AW'($urandom);
      addr1 = AW'($urandom);
      @(negedge clk);
      model_cycle();
      next_edge();
    end

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      model_cycle();
      next_edge();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
